// File: rtl/uart_rx_deframer_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer_pkg
// Shared definitions for the UART receive deframer:
//   - rx_state_e : FSM state encodings (3-bit, fixed values)
//   - OVS        : ticks of sio_ce_x4 per bit time
//   - MID_START  : tcnt value at which the start bit is re-checked
//   - TCNT_LAST  : tcnt value on which a data/parity/stop bit is sampled
// -----------------------------------------------------------------------------
package uart_rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int         OVS       = 4;
  localparam logic [1:0] MID_START = 2'd1;
  localparam logic [1:0] TCNT_LAST = 2'(OVS - 1);

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Multi-flop synchroniser for the raw RXD pad. Every stage resets to 1 so the
// line reads as idle (mark) while and just after reset is applied.
//
// Parameters:
//   SYNC_STAGES - number of flops in the chain (>= 2)
// Ports:
//   hclk    in   system clock
//   hresetn in   asynchronous active-low reset
//   din     in   asynchronous serial input
//   dout    out  synchronised serial input (din delayed SYNC_STAGES clocks)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
// Serial receive front end of the AHB-Lite UART. Synchronises RXD, finds the
// start bit using the 4x-baud tick, shifts in LSB-first data, checks the stop
// bit and hands each good byte to the RX FIFO as a single-cycle strobe.
//
// Build option:
//   UART_RX_PARITY_EN - when defined, an even-parity bit is expected between
//                       the data and stop bits and parity_err_o is added.
//
// Parameters:
//   DATA_BITS   - data bits per frame (5..8)
//   SYNC_STAGES - RXD synchroniser depth (>= 2)
// Ports:
//   hclk         in   system clock
//   hresetn      in   asynchronous active-low reset
//   rxd_i        in   raw serial line, idle high
//   sio_ce_x4    in   one-cycle enable at 4x baud
//   data_o       out  last good byte, held until the next good frame
//   valid_o      out  one-cycle pulse: data_o updated, frame good
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   busy_o       out  receiver is not idle
//   parity_err_o out  (UART_RX_PARITY_EN only) pulses with valid_o on a
//                     parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 rxd_i,
  input  logic                 sio_ce_x4,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err_o
`endif
);

  localparam int             BW        = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0]  BCNT_LAST = BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_e            state_reg, state_next;
  logic [1:0]           tcnt_reg,  tcnt_next;
  logic [BW-1:0]        bcnt_reg,  bcnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg,  data_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg,  ferr_next;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_reg, par_bit_next;
  logic                 perr_reg,    perr_next;
`endif

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .hclk    (hclk),
    .hresetn (hresetn),
    .din     (rxd_i),
    .dout    (rxd_s)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg   <= ST_IDLE;
      tcnt_reg    <= '0;
      bcnt_reg    <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      tcnt_reg    <= tcnt_next;
      bcnt_reg    <= bcnt_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= par_bit_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    tcnt_next    = tcnt_reg;
    bcnt_next    = bcnt_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    // Status strobes default low so they last exactly one hclk, tick or not.
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit_reg;
    perr_next    = 1'b0;
`endif

    if (sio_ce_x4) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_next = ST_START;
            tcnt_next  = '0;
          end
        end

        ST_START: begin
          // Re-check the line half a bit after the falling edge so a glitch
          // shorter than that is rejected as a false start.
          if (tcnt_reg == MID_START) begin
            if (rxd_s) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DATA;
              tcnt_next  = '0;
              bcnt_next  = '0;
            end
          end else begin
            tcnt_next = tcnt_reg + 2'd1;
          end
        end

        ST_DATA: begin
          tcnt_next = tcnt_reg + 2'd1;
          if (tcnt_reg == TCNT_LAST) begin
            // LSB arrives first: insert at the MSB and shift right so the
            // byte is right-aligned after DATA_BITS samples.
            shift_next = {rxd_s, shift_reg[DATA_BITS-1:1]};
            bcnt_next  = bcnt_reg + BW'(1);
            if (bcnt_reg == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          tcnt_next = tcnt_reg + 2'd1;
          if (tcnt_reg == TCNT_LAST) begin
            par_bit_next = rxd_s;
            state_next   = ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          tcnt_next = tcnt_reg + 2'd1;
          if (tcnt_reg == TCNT_LAST) begin
            if (rxd_s) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to zero.
              perr_next  = ^{shift_reg, par_bit_reg};
`endif
              state_next = ST_IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = ST_WAIT_HIGH;
            end
          end
        end

        ST_WAIT_HIGH: begin
          // A held-low line (break) must not be decoded as 0x00 frames.
          if (rxd_s) begin
            state_next = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign data_o      = data_reg;
  assign valid_o     = valid_reg;
  assign frame_err_o = ferr_reg;
  assign busy_o      = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
// Self-checking bench for uart_rx_deframer. A tick is issued every 4 hclk and
// each serial bit lasts 4 ticks. Expected strobes are queued when a frame is
// driven and popped by a monitor when valid_o / frame_err_o fire.
// Build option: UART_RX_PARITY_EN adds the parity port and parity vectors.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

  logic       hclk;
  logic       hresetn;
  logic       rxd_i;
  logic       sio_ce_x4;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  uart_rx_deframer #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .rxd_i       (rxd_i),
    .sio_ce_x4   (sio_ce_x4),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    int         idle_bits;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       perr;
  } sb_t;

  sb_t        sb[$];
  vec_t       vecs[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_good;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One tick period: tick on the first hclk, line value held for all four.
  task automatic window(input logic b);
    rxd_i     = b;
    sio_ce_x4 = 1'b1;
    @(posedge hclk); #1;
    sio_ce_x4 = 1'b0;
    repeat (3) begin
      @(posedge hclk); #1;
    end
  endtask

  task automatic send_bit(input logic b);
    repeat (4) window(b);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(d[k]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("note: parity bit unknown");
`endif
    send_bit(stop);
  endtask

  task automatic expect_pulse(input logic is_err, input logic [7:0] d, input logic perr);
    sb_t e;
    e.is_err = is_err;
    e.data   = d;
    e.perr   = perr;
    sb.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge hclk) begin
    if (hresetn && (valid_o || frame_err_o)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b data=0x%0h expected no pulse at %0t",
                 valid_o, frame_err_o, data_o, $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("pulse_kind", {30'd0, valid_o, frame_err_o}, e.is_err ? 32'd1 : 32'd2);
        check("pulse_data", {24'd0, data_o}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
        check("parity_err", {31'd0, parity_err_o}, {31'd0, e.perr});
`endif
        $display("pulse: valid=%0b ferr=%0b data=0x%0h at %0t", valid_o, frame_err_o, data_o, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // data, parity, stop, idle bits after, exp_valid, exp_ferr, exp_perr
    vecs.push_back('{8'hA5, ^8'hA5, 1'b1, 2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h00, ^8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0});  // back-to-back
    vecs.push_back('{8'hFF, ^8'hFF, 1'b1, 2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hA5, ^8'hA5, 1'b0, 2, 1'b0, 1'b1, 1'b0});  // bad stop
    vecs.push_back('{8'h3C, ^8'h3C, 1'b1, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h55, ^8'h55, 1'b1, 2, 1'b1, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1,   1'b1, 2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h07, 1'b0,   1'b1, 2, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'h5A, ^8'h5A, 1'b1, 2, 1'b1, 1'b0, 1'b0});
`endif

    hresetn   = 1'b0;
    rxd_i     = 1'b1;
    sio_ce_x4 = 1'b0;
    last_good = 8'h00;
    repeat (3) @(posedge hclk);
    #1;
    check("rst_data",  {24'd0, data_o},      32'd0);
    check("rst_valid", {31'd0, valid_o},     32'd0);
    check("rst_ferr",  {31'd0, frame_err_o}, 32'd0);
    check("rst_busy",  {31'd0, busy_o},      32'd0);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    send_bit(1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.exp_ferr) begin
        expect_pulse(1'b1, last_good, 1'b0);
      end else if (v.exp_valid) begin
        expect_pulse(1'b0, v.data, v.exp_perr);
        last_good = v.data;
      end
      send_frame(v.data, v.par_bit, v.stop_bit);
      repeat (v.idle_bits) send_bit(1'b1);
      if (v.idle_bits > 0) check("busy_after_frame", {31'd0, busy_o}, 32'd0);
      $display("vector %0d: data=0x%0h stop=%0b sent", i, v.data, v.stop_bit);
    end

    // False start: one tick of low, then idle.
    window(1'b0);
    window(1'b1);
    check("fs_busy", {31'd0, busy_o}, 32'd1);
    window(1'b1);
    window(1'b1);
    check("fs_idle", {31'd0, busy_o}, 32'd0);
    send_bit(1'b1);
    $display("false start sent");

    // Reset in the middle of 0x3C after its 4th data bit.
    send_bit(1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] part;
      part = 8'h3C;
      send_bit(part[k]);
    end
    hresetn = 1'b0;
    #1;
    check("mid_rst_data",  {24'd0, data_o},      32'd0);
    check("mid_rst_valid", {31'd0, valid_o},     32'd0);
    check("mid_rst_ferr",  {31'd0, frame_err_o}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy_o},      32'd0);
    last_good = 8'h00;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    rxd_i   = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    $display("reset mid-frame applied");

    expect_pulse(1'b0, 8'h81, ^8'h81 ^ ^8'h81);
    last_good = 8'h81;
    send_frame(8'h81, ^8'h81, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    $display("frame 0x81 sent");

    // Break: bad stop bit, line low 3 more bit times, then released.
    expect_pulse(1'b1, last_good, 1'b0);
    send_frame(8'hA5, ^8'hA5, 1'b0);
    repeat (3) send_bit(1'b0);
    check("brk_busy_low", {31'd0, busy_o}, 32'd1);
    window(1'b1);
    check("brk_busy_first_high", {31'd0, busy_o}, 32'd1);
    window(1'b1);
    check("brk_busy_released", {31'd0, busy_o}, 32'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    $display("break sequence sent");

    check("sb_drained", sb.size(), 32'd0);
    check("data_hold", {24'd0, data_o}, 32'h81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial receive front end of the AHB-Lite UART.
- Synchronises the raw RXD pin, detects start bits using the 4x-baud clock enable from the baud-rate generator, and shifts in LSB-first data bits.
- Checks the stop bit, then hands each complete byte to the receive FIFO as a single-cycle write strobe.
- Sits between the RXD pad and the RX FIFO write port.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- SYNC_STAGES, 2, flip-flop depth of the RXD synchroniser (>=2).

Ports:
- hclk  input  1  system clock.
- hresetn  input  1  reset; asynchronous assert, active-low.
- rxd_i  input  1  raw serial line; idle high.
- sio_ce_x4  input  1  one-hclk-cycle enable at 4x baud ("tick").
- data_o  output  DATA_BITS  last received byte, zero-extended; held until the next valid frame.
- valid_o  output  1  one-cycle pulse: data_o updated, frame good.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
Reset:
- On hresetn low, asynchronously clear everything, regardless of current state.
- State = IDLE; data_o = 0; valid_o = 0; frame_err_o = 0; busy_o = 0.
- Synchroniser flops reset to 1; counters reset to 0.

Synchroniser and timing:
- rxd_s = rxd_i after SYNC_STAGES flops.
- All state and counter updates happen only on hclk edges where sio_ce_x4 = 1.
- Exception: valid_o and frame_err_o drop back to 0 on the next hclk regardless of tick.
- tcnt is a 2-bit tick counter.
- bcnt is a bit counter of width clog2(DATA_BITS+1).

States:
- IDLE: on a tick with rxd_s = 0, go to START with tcnt = 0.
- START: each tick increments tcnt. On the tick where tcnt = 1 (2nd tick after detection, mid-bit):
  - rxd_s = 1: false start, return to IDLE with no output.
  - rxd_s = 0: go to DATA with tcnt = 0, bcnt = 0.
- DATA: each tick increments tcnt (wraps 3 -> 0). When tcnt = 3:
  - sample rxd_s into the shift register MSB and shift right (LSB-first reception);
  - bcnt++;
  - when bcnt reaches DATA_BITS, go to PARITY if enabled, else STOP.
- STOP: on the tick where tcnt = 3, sample rxd_s:
  - rxd_s = 1: on the next hclk, data_o <= shift register and valid_o = 1; go to IDLE.
  - rxd_s = 0: frame_err_o = 1, data_o unchanged; go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rxd_s = 1, then go to IDLE. This prevents a break condition from being read as a stream of 0x00 frames.

Rules and boundaries:
- valid_o and frame_err_o are never high in the same cycle.
- No back-pressure: the consumer must accept valid_o in the same cycle. Overrun is the FIFO's concern.
- Back-to-back frames: a start bit directly after the stop bit is detected on the next tick in IDLE. No dead time beyond one tick.
- sio_ce_x4 stuck low: the state machine freezes; outputs hold; pulses still self-clear.
- Reset asserted mid-frame: the partial byte is discarded; valid_o is never issued for it.
- DATA_BITS < 8: data_o upper bits are zero; the shift register is right-aligned on completion.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Add output parity_err_o (1 bit, reset 0).
  - Add state PARITY between DATA and STOP; it samples one bit at tcnt = 3.
  - Even parity is required: XOR of data and parity bit = 0.
  - On mismatch, parity_err_o pulses together with valid_o, and data_o is still updated.
  - On a framing error, parity_err_o stays 0.
- When undefined: no port and no state; DATA goes directly to STOP.

Decomposition:
- Shared include uart_rx_defines.vh:
  - state encodings: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, WAIT_HIGH = 5 (3-bit);
  - tick-per-bit constant OVS = 4;
  - mid-start sample constant = 1.
- One natural sub-module, uart_rx_sync: a parameterised SYNC_STAGES flop chain with reset-to-1 and async active-low reset. The rest stays in a single module.

Test Plan:
- Tick every 4 hclk; send frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one valid_o pulse, data_o = 0xA5, frame_err_o = 0, busy_o low after.
- Same frame with stop bit driven 0, line held low 3 bit-times, then high -> one frame_err_o pulse, no valid_o, data_o keeps its previous value, busy_o stays high until the first high-sampled tick.
- rxd_i low for 1 tick then high -> returns to IDLE, no valid_o, no frame_err_o.
- Frames 0x00 then 0xFF back-to-back with no idle gap -> two valid_o pulses, data_o = 0x00 then 0xFF.
- Drop hresetn for 1 cycle after the 4th data bit of 0x3C, then send 0x81 -> all outputs 0 immediately on reset, no valid_o for 0x3C, next valid_o has data_o = 0x81.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> valid_o, parity_err_o = 0. 0x07 with parity bit 0 -> valid_o and parity_err_o = 1 in the same cycle.
